yuv422_scanout: RTL
===================

# yuv422_scanout

Video scan-out stage between the YUV 4:2:2 frame buffer and the HDMI transmitter. Generates raster timing (hsync/vsync/data-enable) from parameterised counters, drives the frame-buffer read address one pixel per active cycle, and re-aligns the returned 16-bit {chroma, Y} word with the delayed sync signals. Output is a cycle-aligned pixel stream ready for the TMDS/HDMI encoder.

## Interface
- H_ACTIVE, 1280, active pixels per line; must be even.
- H_FP, 110, horizontal front porch in clocks.
- H_SYNC, 40, hsync width in clocks.
- H_BP, 220, horizontal back porch in clocks.
- V_ACTIVE, 720, active lines per frame.
- V_FP, 5, vertical front porch in lines.
- V_SYNC, 5, vsync width in lines.
- V_BP, 20, vertical back porch in lines.
- HS_POL, 1, hsync active level.
- VS_POL, 1, vsync active level.
- RD_LAT, 1, frame-buffer read latency in clocks, from address to data; legal values 1–4.
- ADR_BITS (localparam), $clog2(H_ACTIVE*V_ACTIVE).
- clk_i  in  1  pixel clock.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  scan enable; low holds the raster at origin.
- rd_addr_o  out  ADR_BITS  frame-buffer read address.
- rd_d_i  in  16  frame-buffer read data {chroma[15:8], Y[7:0]}.
- pix_o  out  16  output pixel {chroma, Y}.
- de_o  out  1  data enable (active pixel).
- hsync_o  out  1  horizontal sync.
- vsync_o  out  1  vertical sync.
- frame_start_o  out  1  one-cycle pulse with the first active pixel of each frame.

## Operation
- Counters: hcnt 0..H_TOTAL-1 and vcnt 0..V_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. Region order is active, front porch, sync, back porch. vcnt advances when hcnt wraps. Both wrap to 0 together at the end of the frame.
- Active region: hcnt < H_ACTIVE and vcnt < V_ACTIVE.
- hsync: asserted while H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
- vsync: asserted for whole lines while V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC. Edges align to hcnt = 0.
- Address counter: a running register, not a multiplier.
  - Increments by 1 each active cycle.
  - Clears to 0 instead of reaching H_ACTIVE*V_ACTIVE.
  - Holds during blanking.
  - rd_addr_o is driven directly from this register. At the cycle of active pixel (h, v), rd_addr_o = v*H_ACTIVE + h.
- Alignment: active, hsync, vsync and frame-start flags pass through a shift pipeline of depth RD_LAT+1. rd_d_i is sampled RD_LAT cycles after its address into an output register, so outputs trail the counter state by RD_LAT+1 clocks.
- pix_o:
  - Registered rd_d_i when the delayed active flag is 1.
  - Otherwise the blanking value 16'h8010 (Y=0x10, C=0x80).
- en_i low: hcnt, vcnt and the address counter clear synchronously and the delay pipeline shifts in idle values. Outputs go idle RD_LAT+1 clocks later. On en_i rising, the raster starts at hcnt = 0, vcnt = 0 on the next edge.
- Reset values (asynchronous, on rst_i):
  - counters, address and pipeline: 0
  - rd_addr_o: 0
  - pix_o: 16'h8010
  - de_o: 0
  - hsync_o: !HS_POL
  - vsync_o: !VS_POL
  - frame_start_o: 0
- Reset mid-frame aborts the frame with no partial pulses. After release, behaviour is identical to cold start.

## Timing
- Counter state to outputs: RD_LAT+1 clocks, identical for pix_o, de_o, hsync_o, vsync_o and frame_start_o.
- Address to data: RD_LAT clocks. There is no handshake and the frame buffer is never stalled.
- Exactly one address per clock during active cycles; no gaps within a line.
- Per frame:
  - de_o high for exactly H_ACTIVE*V_ACTIVE cycles.
  - frame_start_o high exactly once, coincident with the first de_o cycle of line 0.
- Chroma phase: H_ACTIVE is even, so rd_addr_o[0] = hcnt[0]. Even pixels carry Cb and odd pixels carry Cr, as muxed by the frame buffer.

## Test plan
All scenarios use H_ACTIVE=8, H_FP=2, H_SYNC=2, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, RD_LAT=1 and a one-cycle-latency memory model returning data {addr[7:0], ~addr[7:0]}.

1. **Reset and idle.** Hold rst_i; then release it with en_i=0 for 20 clocks. Required: all outputs stay at reset values; rd_addr_o=0; pix_o=16'h8010.
2. **Full frame.** en_i=1 for 98 clocks.
   - rd_addr_o steps 0..31 across four 8-cycle active runs.
   - de_o runs are 8 cycles long, starting 2 clocks after each address run.
   - pix_o during de_o = {a, ~a} for a = 0..31, in order.
   - hsync_o high for 2 clocks per line, starting 12 clocks after line start.
3. **Frame wrap.** Run 3 frames. Required: frame_start_o pulses exactly at clocks 2, 100 and 198 after en_i rises; rd_addr_o returns to 0 after 31.
4. **vsync.** Required: vsync_o high for exactly 14 consecutive clocks, starting at line 5 (clock 5*14+2 after en rise), once per frame.
5. **Mid-frame disable.** Drop en_i at address 13, then reassert. Required: de_o falls 2 clocks later with no further frame_start_o; on reassertion the sequence restarts from address 0 with frame_start_o.
6. **Asynchronous reset mid-line.** Assert rst_i between clock edges during active pixel 20. Required: outputs take reset values immediately without a clock edge; after release, scenario 2 repeats exactly.

Source files
------------

// File: rtl/yuv422_scanout.sv
// YUV 4:2:2 scan-out: raster timing, frame-buffer address generation and
// re-alignment of returned pixel data with the delayed sync/enable flags.
module yuv422_scanout #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   RD_LAT   = 1,
  localparam int  ADR_BITS = $clog2(H_ACTIVE * V_ACTIVE)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  output logic [ADR_BITS-1:0] rd_addr_o,
  input  logic [15:0]         rd_d_i,
  output logic [15:0]         pix_o,
  output logic                de_o,
  output logic                hsync_o,
  output logic                vsync_o,
  output logic                frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0]       H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]       H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0]       HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]       HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]       V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]       V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0]       VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]       VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADR_BITS-1:0] ADR_LAST = ADR_BITS'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [15:0]         BLANK_PIX = 16'h8010;

  // Flag bit positions inside each pipeline stage
  localparam int F_ACT = 0;
  localparam int F_HS  = 1;
  localparam int F_VS  = 2;
  localparam int F_FS  = 3;

  logic [HW-1:0]       hcnt_r, hcnt_nx_s;
  logic [VW-1:0]       vcnt_r, vcnt_nx_s;
  logic [ADR_BITS-1:0] addr_r, addr_nx_s;
  logic                act_s;
  logic [3:0]          flag_s;
  logic [RD_LAT-1:0][3:0] pipe_r;
  logic [3:0]          last_s;

  logic [15:0] pix_r;
  logic        de_r;
  logic        hs_r;
  logic        vs_r;
  logic        fs_r;

  // Raster flags for the current counter state; a disabled scan feeds idle flags
  always_comb begin
    act_s  = (hcnt_r < H_ACT) && (vcnt_r < V_ACT);
    flag_s = 4'b0000;
    if (en_i) begin
      flag_s[F_ACT] = act_s;
      flag_s[F_HS]  = (hcnt_r >= HS_START) && (hcnt_r < HS_END);
      flag_s[F_VS]  = (vcnt_r >= VS_START) && (vcnt_r < VS_END);
      flag_s[F_FS]  = (hcnt_r == '0) && (vcnt_r == '0);
    end else begin
      flag_s = 4'b0000;
    end
  end

  // Next raster position and read address; the address is a running count
  always_comb begin
    hcnt_nx_s = hcnt_r;
    vcnt_nx_s = vcnt_r;
    addr_nx_s = addr_r;
    if (!en_i) begin
      hcnt_nx_s = '0;
      vcnt_nx_s = '0;
      addr_nx_s = '0;
    end else begin
      if (hcnt_r == H_LAST) begin
        hcnt_nx_s = '0;
        if (vcnt_r == V_LAST) begin
          vcnt_nx_s = '0;
        end else begin
          vcnt_nx_s = vcnt_r + VW'(1);
        end
      end else begin
        hcnt_nx_s = hcnt_r + HW'(1);
      end
      if (act_s) begin
        if (addr_r == ADR_LAST) begin
          addr_nx_s = '0;
        end else begin
          addr_nx_s = addr_r + ADR_BITS'(1);
        end
      end else begin
        addr_nx_s = addr_r;
      end
    end
  end

  // Counter and address state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_r <= '0;
      vcnt_r <= '0;
      addr_r <= '0;
    end else begin
      hcnt_r <= hcnt_nx_s;
      vcnt_r <= vcnt_nx_s;
      addr_r <= addr_nx_s;
    end
  end

  // Flag delay line matching the frame-buffer read latency
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_r <= '0;
    end else begin
      pipe_r[0] <= flag_s;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign last_s = pipe_r[RD_LAT-1];

  // Output stage: read data lands here in step with its delayed flags
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pix_r <= BLANK_PIX;
      de_r  <= 1'b0;
      hs_r  <= ~HS_POL;
      vs_r  <= ~VS_POL;
      fs_r  <= 1'b0;
    end else begin
      pix_r <= last_s[F_ACT] ? rd_d_i : BLANK_PIX;
      de_r  <= last_s[F_ACT];
      hs_r  <= last_s[F_HS] ? HS_POL : ~HS_POL;
      vs_r  <= last_s[F_VS] ? VS_POL : ~VS_POL;
      fs_r  <= last_s[F_FS];
    end
  end

  assign rd_addr_o     = addr_r;
  assign pix_o         = pix_r;
  assign de_o          = de_r;
  assign hsync_o       = hs_r;
  assign vsync_o       = vs_r;
  assign frame_start_o = fs_r;

endmodule
